// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: default geometry, the "no tag" marker
// used by the map table, and the per-entry record.
package reorder_buffer_pkg;

    localparam int unsigned DEFAULT_ROB_SIZE     = 8;
    localparam int unsigned DEFAULT_ROB_TAG_LEN  = 4;
    localparam int unsigned DEFAULT_REG_ADDR_LEN = 5;
    localparam int unsigned DEFAULT_XLEN         = 32;

    // All-ones tag means "value lives in the register file"; never allocated.
    localparam logic [DEFAULT_ROB_TAG_LEN-1:0] NO_ROB_TAG = '1;

    typedef struct packed {
        logic                            valid;
        logic                            ready;
        logic [DEFAULT_REG_ADDR_LEN-1:0] dest;
        logic [DEFAULT_XLEN-1:0]         value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, captures CDB results,
// serves operand values, and retires in program order.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_SIZE     = DEFAULT_ROB_SIZE,
    parameter int unsigned ROB_TAG_LEN  = DEFAULT_ROB_TAG_LEN,
    parameter int unsigned REG_ADDR_LEN = DEFAULT_REG_ADDR_LEN,
    parameter int unsigned XLEN         = DEFAULT_XLEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    dispatch_valid,
    input  logic [REG_ADDR_LEN-1:0] dispatch_dest,
    output logic                    rob_full,
    output logic [ROB_TAG_LEN-1:0]  assign_rob_tag,
    input  logic                    cdb_valid,
    input  logic [ROB_TAG_LEN-1:0]  cdb_rob_tag,
    input  logic [XLEN-1:0]         cdb_value,
    input  logic [ROB_TAG_LEN-1:0]  src1_rob_tag,
    output logic [XLEN-1:0]         src1_value,
    input  logic [ROB_TAG_LEN-1:0]  src2_rob_tag,
    output logic [XLEN-1:0]         src2_value,
    output logic                    retire_valid,
    output logic [REG_ADDR_LEN-1:0] retire_reg_addr,
    output logic [ROB_TAG_LEN-1:0]  retire_rob_tag,
    output logic [XLEN-1:0]         retire_value
);

    localparam int unsigned PTR_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int unsigned CNT_W = $clog2(ROB_SIZE + 1);
    localparam logic [ROB_TAG_LEN-1:0] TAG_LIMIT = ROB_TAG_LEN'(ROB_SIZE);

    typedef struct packed {
        logic                    valid;
        logic                    ready;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [XLEN-1:0]         value;
    } entry_t;

    entry_t             entries [ROB_SIZE];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               alloc;
    logic               retire;
    logic               cdb_hit;
    logic [PTR_W-1:0]   cdb_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROB_SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // CDB bypass first, then stored value; tags outside the buffer read as zero.
    function automatic logic [XLEN-1:0] read_operand(input logic [ROB_TAG_LEN-1:0] tag);
        if (cdb_valid && (cdb_rob_tag == tag))
            return cdb_value;
        else if (tag < TAG_LIMIT)
            return entries[tag[PTR_W-1:0]].value;
        return '0;
    endfunction

    // Control decodes; full is taken from the registered count so a same-cycle
    // retire never opens a slot for a same-cycle dispatch.
    always_comb begin
        rob_full       = (count == CNT_W'(ROB_SIZE));
        assign_rob_tag = ROB_TAG_LEN'(tail);
        alloc          = dispatch_valid && !rob_full;
        retire         = entries[head].valid && entries[head].ready;
        cdb_idx        = cdb_rob_tag[PTR_W-1:0];
        cdb_hit        = cdb_valid && (cdb_rob_tag < TAG_LIMIT) && entries[cdb_idx].valid;
    end

    // Retire fields come straight from the head entry.
    always_comb begin
        retire_valid    = retire;
        retire_reg_addr = entries[head].dest;
        retire_rob_tag  = ROB_TAG_LEN'(head);
        retire_value    = entries[head].value;
    end

    // Operand lookup for both source ports.
    always_comb begin
        src1_value = read_operand(src1_rob_tag);
        src2_value = read_operand(src2_rob_tag);
    end

    // Entry storage and pointers; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++)
                entries[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) begin
                entries[tail].valid <= 1'b1;
                entries[tail].ready <= 1'b0;
                entries[tail].dest  <= dispatch_dest;
                entries[tail].value <= '0;
                tail                <= ptr_inc(tail);
            end
            if (cdb_hit) begin
                entries[cdb_idx].ready <= 1'b1;
                entries[cdb_idx].value <= cdb_value;
            end
            if (retire) begin
                entries[head].valid <= 1'b0;
                head                <= ptr_inc(head);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(retire);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        dispatch_valid;
    logic [4:0]  dispatch_dest;
    logic        rob_full;
    logic [3:0]  assign_rob_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_tag;
    logic [31:0] cdb_value;
    logic [3:0]  src1_rob_tag;
    logic [31:0] src1_value;
    logic [3:0]  src2_rob_tag;
    logic [31:0] src2_value;
    logic        retire_valid;
    logic [4:0]  retire_reg_addr;
    logic [3:0]  retire_rob_tag;
    logic [31:0] retire_value;

    int tests_run = 0;
    int tests_failed = 0;

    reorder_buffer #(
        .ROB_SIZE    (8),
        .ROB_TAG_LEN (4),
        .REG_ADDR_LEN(5),
        .XLEN        (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .dispatch_dest  (dispatch_dest),
        .rob_full       (rob_full),
        .assign_rob_tag (assign_rob_tag),
        .cdb_valid      (cdb_valid),
        .cdb_rob_tag    (cdb_rob_tag),
        .cdb_value      (cdb_value),
        .src1_rob_tag   (src1_rob_tag),
        .src1_value     (src1_value),
        .src2_rob_tag   (src2_rob_tag),
        .src2_value     (src2_value),
        .retire_valid   (retire_valid),
        .retire_reg_addr(retire_reg_addr),
        .retire_rob_tag (retire_rob_tag),
        .retire_value   (retire_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid   = 1'b1;
        cdb_rob_tag = tag;
        cdb_value   = val;
        tick();
        cdb_valid   = 1'b0;
    endtask

    task automatic dispatch(input logic [4:0] dest);
        dispatch_valid = 1'b1;
        dispatch_dest  = dest;
        tick();
        dispatch_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        dispatch_valid = 1'b0; dispatch_dest = '0;
        cdb_valid = 1'b0; cdb_rob_tag = '0; cdb_value = '0;
        src1_rob_tag = '0; src2_rob_tag = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1. reset state
        check("rst_full", 32'(rob_full), 32'd0);
        check("rst_tag", 32'(assign_rob_tag), 32'd0);
        check("rst_rv", 32'(retire_valid), 32'd0);
        check("rst_rtag", 32'(retire_rob_tag), 32'd0);
        check("rst_raddr", 32'(retire_reg_addr), 32'd0);
        check("rst_rval", retire_value, 32'd0);

        // 2. in-order retire
        check("t2_tag0", 32'(assign_rob_tag), 32'd0);
        dispatch(5'd5);
        check("t2_tag1", 32'(assign_rob_tag), 32'd1);
        dispatch(5'd6);
        check("t2_tag2", 32'(assign_rob_tag), 32'd2);
        dispatch(5'd7);
        check("t2_tag3", 32'(assign_rob_tag), 32'd3);
        cdb(4'd1, 32'hAA);
        check("t2_rv_blocked", 32'(retire_valid), 32'd0);
        cdb(4'd0, 32'h11);
        check("t2_rv0", 32'(retire_valid), 32'd1);
        check("t2_raddr0", 32'(retire_reg_addr), 32'd5);
        check("t2_rtag0", 32'(retire_rob_tag), 32'd0);
        check("t2_rval0", retire_value, 32'h11);
        tick();
        check("t2_rv1", 32'(retire_valid), 32'd1);
        check("t2_raddr1", 32'(retire_reg_addr), 32'd6);
        check("t2_rtag1", 32'(retire_rob_tag), 32'd1);
        check("t2_rval1", retire_value, 32'hAA);
        tick();
        check("t2_rv2", 32'(retire_valid), 32'd0);
        check("t2_rtag2", 32'(retire_rob_tag), 32'd2);

        // 3. fill, overflow attempt, retire frees a slot a cycle later
        do_flush();
        check("t3_flush_tag", 32'(assign_rob_tag), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("t3_full_low", 32'(rob_full), 32'd0);
            dispatch(5'(i + 1));
        end
        check("t3_full", 32'(rob_full), 32'd1);
        check("t3_tag_wrap", 32'(assign_rob_tag), 32'd0);
        dispatch_valid = 1'b1;
        dispatch_dest  = 5'd9;
        tick();
        check("t3_ninth_full", 32'(rob_full), 32'd1);
        check("t3_ninth_tag", 32'(assign_rob_tag), 32'd0);
        cdb_valid = 1'b1; cdb_rob_tag = 4'd0; cdb_value = 32'h77;
        tick();
        cdb_valid = 1'b0;
        check("t3_rv", 32'(retire_valid), 32'd1);
        check("t3_rval", retire_value, 32'h77);
        check("t3_still_full", 32'(rob_full), 32'd1);
        check("t3_tag_hold", 32'(assign_rob_tag), 32'd0);
        tick();
        check("t3_freed", 32'(rob_full), 32'd0);
        check("t3_tag_after", 32'(assign_rob_tag), 32'd0);
        check("t3_rtag_head", 32'(retire_rob_tag), 32'd1);
        tick();
        dispatch_valid = 1'b0;
        check("t3_refull", 32'(rob_full), 32'd1);
        check("t3_tag_next", 32'(assign_rob_tag), 32'd1);
        check("t3_raddr_head", 32'(retire_reg_addr), 32'd2);

        // 4. operand bypass and storage read
        do_flush();
        for (int i = 0; i < 4; i++)
            dispatch(5'(10 + i));
        src1_rob_tag = 4'd3;
        src2_rob_tag = 4'd3;
        cdb_valid = 1'b1; cdb_rob_tag = 4'd3; cdb_value = 32'h55;
        #1;
        check("t4_bypass1", src1_value, 32'h55);
        check("t4_bypass2", src2_value, 32'h55);
        tick();
        cdb_valid = 1'b0;
        #1;
        check("t4_stored", src1_value, 32'h55);
        src2_rob_tag = 4'd1;
        #1;
        check("t4_unwritten", src2_value, 32'd0);
        src2_rob_tag = 4'd9;
        #1;
        check("t4_out_of_range", src2_value, 32'd0);

        // 5. flush beats dispatch
        cdb(4'd2, 32'h22);
        check("t5_rv_pre", 32'(retire_valid), 32'd0);
        check("t5_tag_pre", 32'(assign_rob_tag), 32'd4);
        flush = 1'b1;
        dispatch_valid = 1'b1;
        dispatch_dest = 5'd4;
        tick();
        flush = 1'b0;
        dispatch_valid = 1'b0;
        check("t5_rv", 32'(retire_valid), 32'd0);
        check("t5_tag", 32'(assign_rob_tag), 32'd0);
        check("t5_full", 32'(rob_full), 32'd0);
        check("t5_raddr", 32'(retire_reg_addr), 32'd0);
        src1_rob_tag = 4'd3;
        #1;
        check("t5_cleared_val", src1_value, 32'd0);
        cdb(4'd0, 32'h33);
        check("t5_dropped", 32'(retire_valid), 32'd0);
        check("t5_dropped_val", retire_value, 32'd0);

        // 6. ignored CDB tags
        dispatch(5'd3);
        cdb(4'd15, 32'hDEAD);
        check("t6_tag15", 32'(retire_valid), 32'd0);
        check("t6_tag15_val", retire_value, 32'd0);
        cdb(4'd4, 32'hBEEF);
        check("t6_tag4", 32'(retire_valid), 32'd0);
        src1_rob_tag = 4'd4;
        #1;
        check("t6_tag4_store", src1_value, 32'd0);
        cdb(4'd0, 32'h44);
        check("t6_rv", 32'(retire_valid), 32'd1);
        check("t6_rval", retire_value, 32'h44);
        check("t6_raddr", 32'(retire_reg_addr), 32'd3);
        tick();
        check("t6_rv_done", 32'(retire_valid), 32'd0);
        check("t6_head", 32'(retire_rob_tag), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
